// File: rtl/pipe_addsub_pkg.sv
// Shared helpers for pipe_addsub.
// The chunk width depends on the instantiating module's WIDTH/STAGES, so it
// is provided as a constant function rather than a fixed localparam.
package pipe_addsub_pkg;

  // Bits handled by each pipeline stage.
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal geometry: 1 <= STAGES <= WIDTH and WIDTH splits evenly.
  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_addsub_chunk.sv
// addsub_chunk: combinational CH-bit ripple of full-adder cells.
//   a, b   : chunk operands (b already inverted for subtract)
//   ci     : carry into bit 0
//   s      : chunk sum
//   co     : carry out of the top bit
//   c_msb  : carry into the top bit (signed overflow detection)
module addsub_chunk #(
  parameter int CH = 8
) (
  input  logic [CH-1:0] a,
  input  logic [CH-1:0] b,
  input  logic          ci,
  output logic [CH-1:0] s,
  output logic          co,
  output logic          c_msb
);

  logic [CH:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CH; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[CH];
  assign c_msb = c[CH-1];

endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined ripple-carry adder/subtractor.
// WIDTH bits are split into STAGES chunks; each stage ripples one chunk and
// registers its carry. Upper operand chunks are skewed forward, lower sum
// chunks are de-skewed, so the full result lands aligned after STAGES cycles.
//   clk, rst             : clock, async active-high reset
//   in_valid / in_ready  : operand handshake (in_ready = global advance)
//   a, b, cin, sub       : operands; sub=1 computes a-b and ignores cin
//   out_valid / out_ready: result handshake, full back-pressure
//   sum, cout, ovf, zero : result and flags, registered together
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CH = chunk_w(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic              adv;
  logic [STAGES-1:0] vld_pipe;
  logic [WIDTH-1:0]  b_eff;
  logic [STAGES-1:0] cm_w;

  // Whole pipe moves together; a stalled output freezes every stage.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES-1];
  // Subtract = a + ~b + 1; the +1 enters as stage-0 carry.
  assign b_eff     = sub ? ~b : b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      vld_pipe <= '0;
    else if (adv) vld_pipe <= STAGES'({vld_pipe, in_valid});
  end

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int HI = (k + 1) * CH;

    logic [CH-1:0] ca, cb, cs;
    logic          ci, co;
    logic [HI-1:0] s_nxt;

    if (k == 0) begin : g_in
      assign ca    = a[CH-1:0];
      assign cb    = b_eff[CH-1:0];
      assign ci    = sub | cin;
      assign s_nxt = cs;
    end else begin : g_in
      assign ca    = stg[k-1].g_mid.a_q[k*CH +: CH];
      assign cb    = stg[k-1].g_mid.b_q[k*CH +: CH];
      assign ci    = stg[k-1].g_mid.c_q;
      assign s_nxt = {cs, stg[k-1].g_mid.s_q};
    end

    addsub_chunk #(.CH(CH)) u_chunk (
      .a     (ca),
      .b     (cb),
      .ci    (ci),
      .s     (cs),
      .co    (co),
      .c_msb (cm_w[k])
    );

    if (k < STAGES - 1) begin : g_mid
      // Triangular skew: only the not-yet-added operand bits travel on.
      logic [HI-1:0]    s_q;
      logic             c_q;
      logic [WIDTH-1:HI] a_q, b_q, a_nxt, b_nxt;

      if (k == 0) begin : g_op
        assign a_nxt = a[WIDTH-1:HI];
        assign b_nxt = b_eff[WIDTH-1:HI];
      end else begin : g_op
        assign a_nxt = stg[k-1].g_mid.a_q[WIDTH-1:HI];
        assign b_nxt = stg[k-1].g_mid.b_q[WIDTH-1:HI];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q <= '0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          s_q <= s_nxt;
          c_q <= co;
          a_q <= a_nxt;
          b_q <= b_nxt;
        end
      end
    end else begin : g_fin
      // Final stage doubles as the output register; flags ride with sum.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum  <= '0;
          cout <= 1'b0;
          ovf  <= 1'b0;
          zero <= 1'b0;
        end else if (adv) begin
          sum  <= s_nxt;
          cout <= co;
          ovf  <= co ^ cm_w[k];
          zero <= ~|s_nxt;
        end
      end
    end
  end

endmodule
